roulette_bet_engine: RTL and testbench

Parametrised roulette game core and successor to the single-mode even/odd game. It supports three bet modes: parity, high/low and exact number. Each spin carries a player-selected stake, and payouts are configurable per mode. A fully synchronous FSM resolves each spin and tracks the game-over condition. The block sits between the switch/key inputs plus the random-number generator and the hex/LED display logic.

---
 rtl/roulette_pkg.sv | 21 ++
 rtl/roulette_bet_eval.sv | 49 ++++
 rtl/roulette_bet_engine.sv | 172 +++++++++++++++++
 tb/tb_roulette_bet_engine.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/roulette_pkg.sv
// Shared encodings for the roulette game core: FSM states, bet modes, LED patterns.
package roulette_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_READY   = 3'd1,
    ST_RESOLVE = 3'd2,
    ST_WIN     = 3'd3,
    ST_LOSE    = 3'd4
  } state_t;

  localparam logic [1:0] MODE_PARITY = 2'b00;
  localparam logic [1:0] MODE_HILO   = 2'b01;
  localparam logic [1:0] MODE_EXACT  = 2'b10;

  localparam logic [4:0] LED_WIN_A  = 5'b10101;
  localparam logic [4:0] LED_WIN_B  = 5'b01010;
  localparam logic [4:0] LED_LOSE_A = 5'b11111;
  localparam logic [4:0] LED_OFF    = 5'b00000;

endpackage

// File: rtl/roulette_bet_eval.sv
// Combinational bet evaluator: decides hit/miss for one spin and computes the
// resulting balance, saturating on wins. Stake must already be clamped to balance.
module roulette_bet_eval
  import roulette_pkg::*;
#(
  parameter int BAL_W      = 8,
  parameter int NUM_W      = 6,
  parameter int MAX_NUM    = 36,
  parameter int PAY_PARITY = 1,
  parameter int PAY_EXACT  = 35
) (
  input  logic [NUM_W-1:0] i_num,
  input  logic [1:0]       i_mode,
  input  logic [NUM_W-1:0] i_guess,
  input  logic [BAL_W-1:0] i_stake,
  input  logic [BAL_W-1:0] i_balance,
  output logic             o_hit,
  output logic [BAL_W-1:0] o_next_bal
);

  localparam int EXT_W = BAL_W + 6;
  localparam logic [NUM_W-1:0] HALF = NUM_W'(MAX_NUM / 2);
  localparam logic [EXT_W-1:0] SAT  = {{6{1'b0}}, {BAL_W{1'b1}}};

  logic [EXT_W-1:0] w_pay;
  logic [EXT_W-1:0] w_sum;

  // Hit decision per mode, then payout with saturation or stake deduction.
  always_comb begin
    o_hit      = 1'b0;
    w_pay      = EXT_W'(PAY_PARITY);
    o_next_bal = i_balance;
    case (i_mode)
      MODE_HILO:  o_hit = (i_num != '0) && ((i_num > HALF) == i_guess[0]);
      MODE_EXACT: begin
        o_hit = (i_num == i_guess);
        w_pay = EXT_W'(PAY_EXACT);
      end
      // Reserved mode 11 behaves as parity; zero never counts as even.
      default:    o_hit = (i_num != '0) && ((~i_num[0]) == i_guess[0]);
    endcase
    w_sum = EXT_W'(i_balance) + EXT_W'(i_stake) * w_pay;
    if (o_hit)
      o_next_bal = (w_sum > SAT) ? '1 : w_sum[BAL_W-1:0];
    else
      o_next_bal = i_balance - i_stake;
  end

endmodule

// File: rtl/roulette_bet_engine.sv
// Roulette game core: edge-detects start/spin, captures a bet, resolves it in a
// single RESOLVE cycle, tracks win/lose end states and drives the status LEDs.
module roulette_bet_engine
  import roulette_pkg::*;
#(
  parameter int BAL_W      = 8,
  parameter int NUM_W      = 6,
  parameter int MAX_NUM    = 36,
  parameter int START_BAL  = 10,
  parameter int WIN_BAL    = 20,
  parameter int PAY_PARITY = 1,
  parameter int PAY_EXACT  = 35,
  parameter int FLASH_DIV  = 25000000
) (
  input  logic             Clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic             spin,
  input  logic [1:0]       bet_mode,
  input  logic [NUM_W-1:0] guess,
  input  logic [BAL_W-1:0] bet_amt,
  input  logic [NUM_W-1:0] randnum,
  output logic [BAL_W-1:0] playerBalance,
  output logic [NUM_W-1:0] last_num,
  output logic             result_valid,
  output logic             last_win,
  output logic             spin_reject,
  output logic [2:0]       game_state,
  output logic [4:0]       led_out
);

  localparam int CNT_W = (FLASH_DIV > 1) ? $clog2(FLASH_DIV) : 1;
  localparam logic [CNT_W-1:0] FLASH_LAST = CNT_W'(FLASH_DIV - 1);
  localparam logic [BAL_W-1:0] BAL_START  = BAL_W'(START_BAL);
  localparam logic [BAL_W-1:0] BAL_WIN    = BAL_W'(WIN_BAL);
  localparam logic [NUM_W-1:0] NUM_MAX    = NUM_W'(MAX_NUM);

  state_t           r_state;
  logic [BAL_W-1:0] r_bal;
  logic [NUM_W-1:0] r_last_num;
  logic             r_result_valid;
  logic             r_last_win;
  logic             r_spin_reject;
  logic [4:0]       r_led;
  logic [CNT_W-1:0] r_flash;
  logic             r_start_d;
  logic             r_spin_d;
  logic [NUM_W-1:0] r_num;
  logic [1:0]       r_mode;
  logic [NUM_W-1:0] r_guess;
  logic [BAL_W-1:0] r_stake;

  logic             w_start_edge;
  logic             w_spin_edge;
  logic [BAL_W-1:0] w_stake_raw;
  logic [BAL_W-1:0] w_stake;
  logic             w_hit;
  logic [BAL_W-1:0] w_next_bal;

  assign w_start_edge = start & ~r_start_d;
  assign w_spin_edge  = spin & ~r_spin_d;
  assign w_stake_raw  = (bet_amt == '0) ? BAL_W'(1) : bet_amt;
  assign w_stake      = (w_stake_raw > r_bal) ? r_bal : w_stake_raw;

  roulette_bet_eval #(
    .BAL_W      (BAL_W),
    .NUM_W      (NUM_W),
    .MAX_NUM    (MAX_NUM),
    .PAY_PARITY (PAY_PARITY),
    .PAY_EXACT  (PAY_EXACT)
  ) u_eval (
    .i_num      (r_num),
    .i_mode     (r_mode),
    .i_guess    (r_guess),
    .i_stake    (r_stake),
    .i_balance  (r_bal),
    .o_hit      (w_hit),
    .o_next_bal (w_next_bal)
  );

  // Game FSM with edge detection, bet capture, resolution and LED flashing.
  always_ff @(posedge Clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= ST_IDLE;
      r_bal          <= BAL_START;
      r_last_num     <= '0;
      r_result_valid <= 1'b0;
      r_last_win     <= 1'b0;
      r_spin_reject  <= 1'b0;
      r_led          <= LED_OFF;
      r_flash        <= '0;
      r_start_d      <= 1'b0;
      r_spin_d       <= 1'b0;
      r_num          <= '0;
      r_mode         <= MODE_PARITY;
      r_guess        <= '0;
      r_stake        <= '0;
    end else begin
      r_start_d      <= start;
      r_spin_d       <= spin;
      r_result_valid <= 1'b0;
      r_spin_reject  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_led <= {4'b0000, r_last_win};
          if (w_start_edge) begin
            r_state <= ST_READY;
            r_bal   <= BAL_START;
          end
        end
        ST_READY: begin
          r_led <= {4'b0000, r_last_win};
          if (w_start_edge) begin
            r_bal <= BAL_START;
          end else if (w_spin_edge) begin
            r_num   <= randnum;
            r_mode  <= bet_mode;
            r_guess <= guess;
            r_stake <= w_stake;
            if (randnum > NUM_MAX)
              r_spin_reject <= 1'b1;
            else
              r_state <= ST_RESOLVE;
          end
        end
        ST_RESOLVE: begin
          r_bal          <= w_next_bal;
          r_last_num     <= r_num;
          r_last_win     <= w_hit;
          r_result_valid <= 1'b1;
          r_flash        <= '0;
          if (w_next_bal >= BAL_WIN) begin
            r_state <= ST_WIN;
            r_led   <= LED_WIN_A;
          end else if (w_next_bal == '0) begin
            r_state <= ST_LOSE;
            r_led   <= LED_LOSE_A;
          end else begin
            r_state <= ST_READY;
            r_led   <= {4'b0000, w_hit};
          end
        end
        ST_WIN, ST_LOSE: begin
          if (w_start_edge) begin
            r_state <= ST_READY;
            r_bal   <= BAL_START;
            r_flash <= '0;
            r_led   <= {4'b0000, r_last_win};
          end else if (r_flash == FLASH_LAST) begin
            r_flash <= '0;
            if (r_state == ST_WIN)
              r_led <= (r_led == LED_WIN_A) ? LED_WIN_B : LED_WIN_A;
            else
              r_led <= (r_led == LED_LOSE_A) ? LED_OFF : LED_LOSE_A;
          end else begin
            r_flash <= r_flash + 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign playerBalance = r_bal;
  assign last_num      = r_last_num;
  assign result_valid  = r_result_valid;
  assign last_win      = r_last_win;
  assign spin_reject   = r_spin_reject;
  assign game_state    = r_state;
  assign led_out       = r_led;

endmodule

// File: tb/tb_roulette_bet_engine.sv
// Directed self-checking bench for roulette_bet_engine (FLASH_DIV shortened to 4).
module tb_roulette_bet_engine;

  logic       Clock = 1'b0;
  logic       reset_n;
  logic       start;
  logic       spin;
  logic [1:0] bet_mode;
  logic [5:0] guess;
  logic [7:0] bet_amt;
  logic [5:0] randnum;
  logic [7:0] playerBalance;
  logic [5:0] last_num;
  logic       result_valid;
  logic       last_win;
  logic       spin_reject;
  logic [2:0] game_state;
  logic [4:0] led_out;

  int n_cmp  = 0;
  int n_fail = 0;
  int pulses;

  roulette_bet_engine #(
    .BAL_W      (8),
    .NUM_W      (6),
    .MAX_NUM    (36),
    .START_BAL  (10),
    .WIN_BAL    (20),
    .PAY_PARITY (1),
    .PAY_EXACT  (35),
    .FLASH_DIV  (4)
  ) dut (
    .Clock         (Clock),
    .reset_n       (reset_n),
    .start         (start),
    .spin          (spin),
    .bet_mode      (bet_mode),
    .guess         (guess),
    .bet_amt       (bet_amt),
    .randnum       (randnum),
    .playerBalance (playerBalance),
    .last_num      (last_num),
    .result_valid  (result_valid),
    .last_win      (last_win),
    .spin_reject   (spin_reject),
    .game_state    (game_state),
    .led_out       (led_out)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic restart();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("restart_bal", 32'(playerBalance), 32'd10);
    check("restart_state", 32'(game_state), 32'd1);
  endtask

  // Raises spin with the given bet and advances to the cycle where the result shows.
  task automatic do_spin(input logic [1:0] m, input logic [5:0] g,
                         input logic [7:0] amt, input logic [5:0] num);
    bet_mode = m;
    guess    = g;
    bet_amt  = amt;
    randnum  = num;
    spin     = 1'b1;
    tick();
    check("resolve_state", 32'(game_state), 32'd2);
    tick();
    check("valid_pulse", 32'(result_valid), 32'd1);
  endtask

  task automatic release_spin();
    spin = 1'b0;
    tick();
    check("valid_drop", 32'(result_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n = 1'b0; start = 1'b0; spin = 1'b0;
    bet_mode = 2'b00; guess = '0; bet_amt = '0; randnum = '0;
    tick(); tick();
    check("rst_state", 32'(game_state), 32'd0);
    check("rst_bal", 32'(playerBalance), 32'd10);
    check("rst_last_num", 32'(last_num), 32'd0);
    check("rst_valid", 32'(result_valid), 32'd0);
    check("rst_win", 32'(last_win), 32'd0);
    check("rst_reject", 32'(spin_reject), 32'd0);
    check("rst_led", 32'(led_out), 32'd0);
    reset_n = 1'b1;
    tick();
    check("idle_hold", 32'(game_state), 32'd0);

    // Parity even, 8 hits: 10 + 2 = 12
    restart();
    do_spin(2'b00, 6'd1, 8'd2, 6'd8);
    check("par_bal", 32'(playerBalance), 32'd12);
    check("par_win", 32'(last_win), 32'd1);
    check("par_num", 32'(last_num), 32'd8);
    check("par_state", 32'(game_state), 32'd1);
    check("par_led", 32'(led_out), 32'd1);
    release_spin();

    // Zero always loses: 10 - 3 = 7
    restart();
    do_spin(2'b00, 6'd1, 8'd3, 6'd0);
    check("zero_bal", 32'(playerBalance), 32'd7);
    check("zero_win", 32'(last_win), 32'd0);
    release_spin();

    // High/low boundary: 18 is low, 19 is high; bet_amt 0 acts as 1
    restart();
    do_spin(2'b01, 6'd1, 8'd2, 6'd18);
    check("hilo18_high_bal", 32'(playerBalance), 32'd8);
    release_spin();
    do_spin(2'b01, 6'd0, 8'd2, 6'd18);
    check("hilo18_low_bal", 32'(playerBalance), 32'd10);
    release_spin();
    do_spin(2'b01, 6'd1, 8'd0, 6'd19);
    check("hilo19_zero_stake_bal", 32'(playerBalance), 32'd11);
    release_spin();

    // Reserved mode behaves as parity: odd guess, 7 hits: 11 + 1 = 12
    do_spin(2'b11, 6'd0, 8'd1, 6'd7);
    check("mode3_bal", 32'(playerBalance), 32'd12);
    release_spin();

    // Exact 17: 10 + 35 = 45 -> WIN, LED flashing period 4
    restart();
    do_spin(2'b10, 6'd17, 8'd1, 6'd17);
    check("exact_bal", 32'(playerBalance), 32'd45);
    check("exact_state", 32'(game_state), 32'd3);
    check("win_led0", 32'(led_out), 32'b10101);
    release_spin();
    tick(); tick();
    check("win_led_hold", 32'(led_out), 32'b10101);
    tick();
    check("win_led_toggle", 32'(led_out), 32'b01010);
    spin = 1'b1;
    tick();
    check("win_spin_ignored_state", 32'(game_state), 32'd3);
    check("win_spin_ignored_bal", 32'(playerBalance), 32'd45);
    check("win_spin_no_valid", 32'(result_valid), 32'd0);
    spin = 1'b0;
    tick(); tick();
    check("win_led_hold2", 32'(led_out), 32'b01010);
    tick();
    check("win_led_back", 32'(led_out), 32'b10101);
    start = 1'b1;
    tick();
    check("win_restart_state", 32'(game_state), 32'd1);
    check("win_restart_bal", 32'(playerBalance), 32'd10);
    start = 1'b0;
    tick();

    // Exact hit saturates: 10 + 10*35 = 360 -> 255
    do_spin(2'b10, 6'd5, 8'd10, 6'd5);
    check("sat_bal", 32'(playerBalance), 32'd255);
    release_spin();

    // Down to 1, then stake 5 clamps to 1 -> 0 -> LOSE
    restart();
    do_spin(2'b00, 6'd1, 8'd9, 6'd0);
    check("lose_pre_bal", 32'(playerBalance), 32'd1);
    release_spin();
    do_spin(2'b00, 6'd1, 8'd5, 6'd0);
    check("clamp_bal", 32'(playerBalance), 32'd0);
    check("lose_state", 32'(game_state), 32'd4);
    check("lose_led0", 32'(led_out), 32'b11111);
    release_spin();
    tick(); tick();
    check("lose_led_hold", 32'(led_out), 32'b11111);
    tick();
    check("lose_led_toggle", 32'(led_out), 32'b00000);

    // Out-of-range number rejected
    restart();
    bet_mode = 2'b00; guess = 6'd1; bet_amt = 8'd2; randnum = 6'd40;
    spin = 1'b1;
    tick();
    check("rej_pulse", 32'(spin_reject), 32'd1);
    check("rej_state", 32'(game_state), 32'd1);
    check("rej_valid", 32'(result_valid), 32'd0);
    tick();
    check("rej_drop", 32'(spin_reject), 32'd0);
    check("rej_bal", 32'(playerBalance), 32'd10);
    spin = 1'b0;
    tick();

    // Held spin resolves exactly once
    randnum = 6'd8;
    spin = 1'b1;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (result_valid) pulses++;
    end
    spin = 1'b0;
    tick(); tick();
    check("held_pulses", 32'(pulses), 32'd1);
    check("held_bal", 32'(playerBalance), 32'd12);

    // Start and spin edges together: start wins
    start = 1'b1; spin = 1'b1;
    tick();
    check("both_bal", 32'(playerBalance), 32'd10);
    check("both_state", 32'(game_state), 32'd1);
    tick();
    check("both_no_valid", 32'(result_valid), 32'd0);
    start = 1'b0; spin = 1'b0;
    tick();

    // Reset asserted during RESOLVE
    restart();
    bet_amt = 8'd2; randnum = 6'd8;
    spin = 1'b1;
    tick();
    check("mid_resolve", 32'(game_state), 32'd2);
    reset_n = 1'b0;
    #1;
    check("mid_rst_state", 32'(game_state), 32'd0);
    check("mid_rst_bal", 32'(playerBalance), 32'd10);
    tick();
    check("mid_rst_valid", 32'(result_valid), 32'd0);
    check("mid_rst_bal2", 32'(playerBalance), 32'd10);
    reset_n = 1'b1;
    spin = 1'b0;
    tick();
    check("post_rst_state", 32'(game_state), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
